modport_source: RTL and testbench
=================================

# modport_source

Source-side stream/address front end: passes a byte stream and its ready/valid handshake straight through, registers a copy of each data byte, and packs accepted bytes into 32-bit words. Each completed word is compared against one of two 32-bit addresses. In the design, each address comes from the `addr` field of one of two interface instances viewed through their `source` modport; here those fields are flattened onto plain ports. The block sits between an upstream byte producer and a downstream consumer, and flags words that match the selected address.

## Interface

Parameters:
- `ADDR_W`, default 32: address and word width. It must equal `8*BEATS`.
- `BEATS`, default 4: number of bytes per assembled word.

Ports:
- `clk`, input, 1 bit: the only clock; everything is rising-edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `stream_in_valid`, input, 1 bit: upstream byte valid.
- `stream_in_ready`, output, 1 bit: ready to upstream.
- `stream_in_data`, input, 8 bits: upstream byte.
- `stream_out_ready`, input, 1 bit: downstream ready.
- `stream_out_data_comb`, output, 8 bits: combinational copy of `stream_in_data`.
- `stream_out_data_registered`, output, 8 bits: `stream_in_data` delayed by one cycle.
- `and_output`, output, 1 bit: equals `stream_in_ready & stream_in_valid`, which is the accept strobe.
- `src_addr_0`, input, `ADDR_W` bits: `addr` from interface instance 0 (`source` modport).
- `src_addr_1`, input, `ADDR_W` bits: `addr` from interface instance 1 (`source` modport).
- `addr_sel`, input, 1 bit: 0 selects `src_addr_0`, 1 selects `src_addr_1`.
- `word_out`, output, `ADDR_W` bits: last assembled word.
- `word_valid`, output, 1 bit: one-cycle pulse when `word_out` updates.
- `addr_hit`, output, 1 bit: the assembled word equals the selected address; valid while `word_valid` is high.
- `beat_count`, output, 2 bits: number of bytes currently held in the partial word.

## Operation

- `stream_in_ready = stream_out_ready`. This path is purely combinational and is unaffected by `rst`.
- `stream_out_data_comb = stream_in_data`. Combinational, unaffected by `rst`.
- `and_output = stream_in_ready & stream_in_valid`. This is the accept condition and is unaffected by `rst`.
- `stream_out_data_registered` captures `stream_in_data` on every clock edge, regardless of valid or ready.
- Byte buffer:
  - A 4-entry by 8-bit buffer is indexed by `beat_count`.
  - On an accept, the byte is written to entry `beat_count`, and `beat_count` increments, wrapping from 3 to 0.
- Word assembly on the accept where `beat_count == 3`:
  - `word_out <= {stream_in_data, buf[2], buf[1], buf[0]}`, i.e. little-endian: the first byte goes to `[7:0]`.
  - `addr_hit <=` the same word compared for equality against `addr_sel ? src_addr_1 : src_addr_0`. Both the address and `addr_sel` are sampled at that same edge.
  - `word_valid <= 1`.
- On every other edge:
  - `word_valid <= 0`.
  - `word_out` and `addr_hit` hold their values.
- No backpressure is generated internally. Bytes that are not accepted are not counted.

## Timing

- Reset values are applied at the first rising edge with `rst=1`:
  - `stream_out_data_registered=0`
  - `word_out=0`
  - `word_valid=0`
  - `addr_hit=0`
  - `beat_count=0`
  - all buffer entries 0
- Combinational outputs follow their inputs even during reset.
- Reset has priority over an accept on the same edge. A partial word is discarded and counting restarts at byte 0.
- Latency:
  - `stream_out_data_registered`: 1 cycle.
  - `word_out`, `word_valid` and `addr_hit`: valid in the cycle after the 4th accepted byte's edge.
- With back-to-back accepts, `word_valid` pulses exactly once every 4 cycles and is never high for two consecutive cycles.
- Address changes between words have no effect. Only the value at the completing edge matters.
- Idle cycles (no accept) between bytes of a word are allowed. The partial state persists indefinitely.

## Test plan

- **Reset:** hold `rst=1` for 2 cycles with random inputs. Then `stream_out_data_registered=0`, `word_valid=0`, `addr_hit=0`, `word_out=0` and `beat_count=0`, while `stream_in_ready` tracks `stream_out_ready`.
- **Passthrough:** drive `stream_in_data=0x5A` then `0xA5`. `stream_out_data_comb` changes immediately, and `stream_out_data_registered` shows `0x5A` then `0xA5`, each one cycle later. Toggle `stream_out_ready` and check that `stream_in_ready` and `and_output = ready & valid` follow in the same cycle.
- **Word hit:**
  - Setup: `src_addr_0=0x12345678`, `addr_sel=0`.
  - Stimulus: accept bytes `0x78`, `0x56`, `0x34`, `0x12` back-to-back.
  - Required: the next cycle has `word_out=0x12345678`, `word_valid=1`, `addr_hit=1`, and `word_valid=0` one cycle later.
- **Select and miss:**
  - Setup: `src_addr_1=0xDEADBEEF`, `addr_sel=1`.
  - Stimulus: the same four bytes as the hit case.
  - Required: `addr_hit=0`. Sending `EF`, `BE`, `AD`, `DE` then gives `addr_hit=1`.
- **Gaps and wrap:**
  - Stimulus: interleave idle cycles and valid bytes held off by `stream_out_ready=0` while sending 8 accepted bytes.
  - Required: exactly 2 `word_valid` pulses; `beat_count` sequence 0,1,2,3,0,…; stalled bytes are never counted.
- **Reset mid-word:** accept 2 bytes, assert `rst` for 1 cycle, then accept 4 bytes `01`, `02`, `03`, `04`. Required: a single word `0x04030201`.

Source files
------------

// File: rtl/modport_source.sv
// -----------------------------------------------------------------------------
// modport_source
//
// Source-side stream/address front end. A byte stream and its ready/valid
// handshake pass straight through; a registered copy of each byte is kept;
// accepted bytes are packed little-endian into ADDR_W-bit words. Each completed
// word is compared for equality against one of two addresses (the flattened
// `addr` fields of two interface instances seen through their source modport).
//
// Handshake: a byte is accepted on a rising edge where stream_in_valid and
// stream_in_ready are both high (and_output exposes that strobe). Ready is a
// pure combinational copy of the downstream ready; this block never stalls.
//
// Ports:
//   clk, rst                    rising-edge clock, synchronous active-high reset
//   stream_in_valid/ready/data  upstream byte handshake
//   stream_out_ready            downstream ready (drives stream_in_ready)
//   stream_out_data_comb        combinational copy of stream_in_data
//   stream_out_data_registered  stream_in_data delayed one cycle
//   and_output                  accept strobe (ready & valid)
//   src_addr_0, src_addr_1      candidate addresses
//   addr_sel                    0 -> src_addr_0, 1 -> src_addr_1
//   word_out                    last assembled word
//   word_valid                  one-cycle pulse when word_out updates
//   addr_hit                    word_out matched the selected address
//   beat_count                  bytes held in the partial word (debug view)
// -----------------------------------------------------------------------------
module modport_source #(
    parameter int ADDR_W = 32,
    parameter int BEATS  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stream_in_valid,
    output logic              stream_in_ready,
    input  logic [7:0]        stream_in_data,
    input  logic              stream_out_ready,
    output logic [7:0]        stream_out_data_comb,
    output logic [7:0]        stream_out_data_registered,
    output logic              and_output,
    input  logic [ADDR_W-1:0] src_addr_0,
    input  logic [ADDR_W-1:0] src_addr_1,
    input  logic              addr_sel,
    output logic [ADDR_W-1:0] word_out,
    output logic              word_valid,
    output logic              addr_hit,
    output logic [1:0]        beat_count
);

    logic [7:0]        buf_q [BEATS];
    logic              accept;
    logic              last_beat;
    logic [ADDR_W-1:0] assembled;
    logic [ADDR_W-1:0] sel_addr;

    // Passthrough paths: combinational and independent of reset.
    assign stream_in_ready      = stream_out_ready;
    assign stream_out_data_comb = stream_in_data;
    assign accept               = stream_out_ready & stream_in_valid;
    assign and_output           = accept;

    assign last_beat = (beat_count == 2'(BEATS - 1));
    assign sel_addr  = addr_sel ? src_addr_1 : src_addr_0;

    // Word formed on the completing beat: the buffered bytes fill the low
    // lanes (first byte in [7:0]) and the byte being accepted now fills the top.
    always_comb begin
        assembled = '0;
        for (int i = 0; i < BEATS - 1; i++) begin
            assembled[i*8 +: 8] = buf_q[i];
        end
        assembled[ADDR_W-1 -: 8] = stream_in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stream_out_data_registered <= 8'h00;
            word_out                   <= '0;
            word_valid                 <= 1'b0;
            addr_hit                   <= 1'b0;
            beat_count                 <= 2'd0;
            for (int i = 0; i < BEATS; i++) begin
                buf_q[i] <= 8'h00;
            end
        end else begin
            stream_out_data_registered <= stream_in_data;
            word_valid                 <= 1'b0;
            if (accept) begin
                buf_q[beat_count] <= stream_in_data;
                if (last_beat) begin
                    beat_count <= 2'd0;
                    word_out   <= assembled;
                    addr_hit   <= (assembled == sel_addr);
                    word_valid <= 1'b1;
                end else begin
                    beat_count <= beat_count + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_modport_source.sv
// -----------------------------------------------------------------------------
// tb_modport_source
//
// Directed and randomized stimulus for modport_source. A behavioural model
// keeps accepted bytes in a queue; every fourth byte forms a word whose
// expected value goes into exp_q, which is drained whenever the DUT pulses
// word_valid.
// -----------------------------------------------------------------------------
module tb_modport_source;

    localparam int ADDR_W = 32;
    localparam int BEATS  = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              stream_in_valid;
    logic              stream_in_ready;
    logic [7:0]        stream_in_data;
    logic              stream_out_ready;
    logic [7:0]        stream_out_data_comb;
    logic [7:0]        stream_out_data_registered;
    logic              and_output;
    logic [ADDR_W-1:0] src_addr_0;
    logic [ADDR_W-1:0] src_addr_1;
    logic              addr_sel;
    logic [ADDR_W-1:0] word_out;
    logic              word_valid;
    logic              addr_hit;
    logic [1:0]        beat_count;

    modport_source #(.ADDR_W(ADDR_W), .BEATS(BEATS)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .stream_in_valid            (stream_in_valid),
        .stream_in_ready            (stream_in_ready),
        .stream_in_data             (stream_in_data),
        .stream_out_ready           (stream_out_ready),
        .stream_out_data_comb       (stream_out_data_comb),
        .stream_out_data_registered (stream_out_data_registered),
        .and_output                 (and_output),
        .src_addr_0                 (src_addr_0),
        .src_addr_1                 (src_addr_1),
        .addr_sel                   (addr_sel),
        .word_out                   (word_out),
        .word_valid                 (word_valid),
        .addr_hit                   (addr_hit),
        .beat_count                 (beat_count)
    );

    // ---------------- scoreboard / model state ----------------
    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [ADDR_W-1:0] exp_q [$];
    logic [7:0]        part_q [$];
    logic [7:0]        exp_reg  = 8'h00;
    logic [ADDR_W-1:0] exp_word = '0;
    logic              exp_hit  = 1'b0;
    logic              exp_valid = 1'b0;
    logic              prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Behavioural model: applied with the inputs present at the rising edge.
    task automatic model_edge();
        logic [ADDR_W-1:0] w;
        if (rst) begin
            exp_reg   = 8'h00;
            exp_word  = '0;
            exp_hit   = 1'b0;
            exp_valid = 1'b0;
            part_q.delete();
        end else begin
            exp_reg   = stream_in_data;
            exp_valid = 1'b0;
            if (stream_out_ready && stream_in_valid) begin
                part_q.push_back(stream_in_data);
                if (part_q.size() == BEATS) begin
                    w = {part_q[3], part_q[2], part_q[1], part_q[0]};
                    exp_word  = w;
                    exp_hit   = (w == (addr_sel ? src_addr_1 : src_addr_0));
                    exp_valid = 1'b1;
                    exp_q.push_back(w);
                    part_q.delete();
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic r, input logic [7:0] d);
        stream_in_valid  = v;
        stream_out_ready = r;
        stream_in_data   = d;
    endtask

    // One clock: combinational checks mid-cycle, edge, model, registered checks.
    task automatic step();
        #1;
        chk("in_ready", {31'd0, stream_in_ready}, {31'd0, stream_out_ready});
        chk("data_comb", {24'd0, stream_out_data_comb}, {24'd0, stream_in_data});
        chk("and_output", {31'd0, and_output}, {31'd0, stream_out_ready & stream_in_valid});
        @(posedge clk);
        model_edge();
        #1;
        chk("data_reg", {24'd0, stream_out_data_registered}, {24'd0, exp_reg});
        chk("word_valid", {31'd0, word_valid}, {31'd0, exp_valid});
        chk("beat_count", {30'd0, beat_count}, part_q.size());
        chk("word_out", word_out, exp_word);
        chk("addr_hit", {31'd0, addr_hit}, {31'd0, exp_hit});
        if (word_valid) begin
            pulses++;
            chk("valid_twice", {31'd0, prev_valid}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_word", word_out, 32'hxxxxxxxx);
            end else begin
                chk("sb_word", word_out, exp_q.pop_front());
            end
        end
        prev_valid = word_valid;
    endtask

    task automatic send_byte(input logic [7:0] d);
        drive(1'b1, 1'b1, d);
        step();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
            step();
        end
        rst = 1'b0;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int p0;
        int accepted;
        rst = 1'b1;
        src_addr_0 = 32'h12345678;
        src_addr_1 = 32'hDEADBEEF;
        addr_sel   = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        @(posedge clk);
        model_edge();

        // Reset with random inputs.
        do_reset(2);
        chk("rst_word_out", word_out, 32'h0);
        chk("rst_beat_count", {30'd0, beat_count}, 32'd0);
        chk("rst_data_reg", {24'd0, stream_out_data_registered}, 32'd0);

        // Passthrough.
        drive(1'b0, 1'b0, 8'h5A); step();
        chk("pt_reg_5a", {24'd0, stream_out_data_registered}, 32'h5A);
        drive(1'b0, 1'b1, 8'hA5); step();
        chk("pt_reg_a5", {24'd0, stream_out_data_registered}, 32'hA5);
        drive(1'b1, 1'b0, 8'h11); step();
        drive(1'b1, 1'b1, 8'h22); step();
        do_reset(1);

        // Word hit through src_addr_0.
        addr_sel = 1'b0;
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        chk("hit_word", word_out, 32'h12345678);
        chk("hit_valid", {31'd0, word_valid}, 32'd1);
        chk("hit_hit", {31'd0, addr_hit}, 32'd1);
        drive(1'b0, 1'b1, 8'h00); step();
        chk("hit_valid_drop", {31'd0, word_valid}, 32'd0);

        // Select src_addr_1: miss, then hit.
        addr_sel = 1'b1;
        send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
        chk("sel_miss", {31'd0, addr_hit}, 32'd0);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        chk("sel_hit", {31'd0, addr_hit}, 32'd1);
        chk("sel_word", word_out, 32'hDEADBEEF);

        // Gaps and stalls across 8 accepted bytes.
        p0 = pulses;
        accepted = 0;
        while (accepted < 8) begin
            case ($urandom_range(0, 2))
                0: drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
                1: drive(1'b1, 1'b0, 8'($urandom));
                default: begin
                    drive(1'b1, 1'b1, 8'($urandom));
                    accepted++;
                end
            endcase
            step();
        end
        chk("gap_pulses", pulses - p0, 32'd2);

        // Reset mid-word discards the partial bytes.
        addr_sel = 1'b0;
        send_byte(8'hAA); send_byte(8'hBB);
        do_reset(1);
        p0 = pulses;
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("midrst_word", word_out, 32'h04030201);
        drive(1'b0, 1'b0, 8'h00); step();
        chk("midrst_pulses", pulses - p0, 32'd1);

        // Random traffic; narrow byte/address alphabet makes hits likely.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                src_addr_0 = {4{8'($urandom_range(0, 1))}};
                src_addr_1 = 32'($urandom);
            end
            addr_sel = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 99) == 0);
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 1)) : 8'($urandom));
            step();
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00); step();
        chk("sb_drained", exp_q.size(), 32'd0);

        // ---------------- final report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
